// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue -- show-ahead instruction FIFO between fetch and decode.
//
// Each entry holds the fetched instruction word, its PC, and PC+4. The head
// entry is always visible on the outputs. A dequeue pops the head only when
// decode asks for it, the pipe is not frozen, and no redirect is in flight.
// When the queue is empty, the outputs are zero, so decode sees a NOP.
//
// Configuration:
//   IQ_BYPASS_EN  When defined, an offer made while the queue is empty
//                 falls straight through to the outputs in the same cycle.
//                 If decode consumes it in that cycle, it is never stored.
//                 When undefined, an enqueued entry becomes visible exactly
//                 one cycle later, and Instr1_Valid_OUT comes purely from
//                 registered state.
//
// Parameters:
//   DEPTH               number of entries (power of two, 2..64)
//
// Ports:
//   CLK                 clock; all state changes on posedge
//   RESET               synchronous, active-high; overrides everything
//   Instr_IN            fetched instruction word
//   Instr_PC_IN         PC of Instr_IN
//   Instr_PC_Plus4_IN   PC+4 of Instr_IN
//   Instr_Valid_IN      fetch offers an entry this cycle
//   Full_OUT            queue cannot accept; fetch holds its PC
//   Request_Instr1      decode is ready to consume the head entry
//   Stall_IN            downstream freeze; blocks dequeue, not enqueue
//   Flush_IN            redirect taken; all entries are discarded
//   Instr1_OUT          head instruction
//   Instr_PC_OUT        head PC
//   Instr_PC_Plus4_OUT  head PC+4
//   Instr1_Valid_OUT    head outputs are valid
//   Count_OUT           current occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module instr_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              Instr_IN,
  input  logic [31:0]              Instr_PC_IN,
  input  logic [31:0]              Instr_PC_Plus4_IN,
  input  logic                     Instr_Valid_IN,
  output logic                     Full_OUT,
  input  logic                     Request_Instr1,
  input  logic                     Stall_IN,
  input  logic                     Flush_IN,
  output logic [31:0]              Instr1_OUT,
  output logic [31:0]              Instr_PC_OUT,
  output logic [31:0]              Instr_PC_Plus4_OUT,
  output logic                     Instr1_Valid_OUT,
  output logic [$clog2(DEPTH):0]   Count_OUT
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;

  entry_t in_e, head_e, out_e;
  logic   empty, full, byp, deq, enq, push, pop;

  assign in_e   = '{instr: Instr_IN, pc: Instr_PC_IN, pc4: Instr_PC_Plus4_IN};
  assign head_e = mem[head];

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);

`ifdef IQ_BYPASS_EN
  // The fall-through path is gated by RESET so that a reset cycle never
  // advertises a valid head.
  assign byp = empty & Instr_Valid_IN & ~Flush_IN & ~RESET;
`else
  assign byp = 1'b0;
`endif

  assign Instr1_Valid_OUT = ~empty | byp;

  always_comb begin
    out_e = '0;
    if (!empty)   out_e = head_e;
    else if (byp) out_e = in_e;
  end

  assign Instr1_OUT         = out_e.instr;
  assign Instr_PC_OUT       = out_e.pc;
  assign Instr_PC_Plus4_OUT = out_e.pc4;
  assign Full_OUT           = full;
  assign Count_OUT          = count;

  // An offer while full is refused even if the head leaves this cycle.
  // This keeps Full_OUT a pure function of registered state.
  assign deq = Request_Instr1 & Instr1_Valid_OUT & ~Stall_IN & ~Flush_IN;
  assign enq = Instr_Valid_IN & ~full & ~Flush_IN;

  // A bypassed entry that is consumed in the same cycle never touches storage.
  // A bypass dequeue pops nothing, because the queue is empty.
  assign push = enq & ~(byp & deq);
  assign pop  = deq & ~byp;

  always_ff @(posedge CLK) begin
    if (RESET || Flush_IN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // The pointers are exactly AW bits wide, so they wrap DEPTH-1 -> 0 naturally.
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries past the pointers are never observed.
  always_ff @(posedge CLK) begin
    if (!RESET && push) mem[tail] <= in_e;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue (DEPTH=8). The stimulus pushes the PC of
// every offer it expects to be accepted. The monitor pops and compares on
// every cycle in which the DUT performs a dequeue.
module tb_instr_queue;
  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr_IN, Instr_PC_IN, Instr_PC_Plus4_IN;
  logic        Instr_Valid_IN, Full_OUT, Request_Instr1, Stall_IN, Flush_IN;
  logic [31:0] Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT;
  logic        Instr1_Valid_OUT;
  logic [$clog2(DEPTH):0] Count_OUT;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN),
    .Instr_PC_Plus4_IN(Instr_PC_Plus4_IN), .Instr_Valid_IN(Instr_Valid_IN),
    .Full_OUT(Full_OUT), .Request_Instr1(Request_Instr1),
    .Stall_IN(Stall_IN), .Flush_IN(Flush_IN),
    .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
    .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
    .Instr1_Valid_OUT(Instr1_Valid_OUT), .Count_OUT(Count_OUT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive after posedge, then return at negedge. The count
  // check uses the occupancy during this cycle, i.e. before the next edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic req,
                      input logic stall, input logic flush, input logic rst,
                      input logic acc, input int exp_cnt);
    @(posedge CLK); #1;
    RESET = rst; Instr_Valid_IN = v; Instr_PC_IN = pc;
    Instr_IN = instr_of(pc); Instr_PC_Plus4_IN = pc + 32'd4;
    Request_Instr1 = req; Stall_IN = stall; Flush_IN = flush;
    if (flush || rst) sb.delete();
    if (acc) sb.push_back(pc);
    @(negedge CLK);
    if (exp_cnt >= 0) chk("count", 32'(Count_OUT), 32'(exp_cnt));
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_valid"}, 32'(Instr1_Valid_OUT), 32'd0);
    chk({tag, "_instr"}, Instr1_OUT, 32'd0);
    chk({tag, "_pc"},    Instr_PC_OUT, 32'd0);
    chk({tag, "_pc4"},   Instr_PC_Plus4_OUT, 32'd0);
  endtask

  // Monitor: a dequeue happens at the coming edge whenever these hold.
  always @(negedge CLK) begin
    if (RESET === 1'b0 && Request_Instr1 && !Stall_IN && !Flush_IN &&
        Instr1_Valid_OUT === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL deq_unexpected: got pc %h expected no entry", Instr_PC_OUT);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("deq_pc",    Instr_PC_OUT, e);
        chk("deq_instr", Instr1_OUT, instr_of(e));
        chk("deq_pc4",   Instr_PC_Plus4_OUT, e + 32'd4);
      end
    end
  end

  initial begin
    RESET = 1'b1; Instr_IN = '0; Instr_PC_IN = '0; Instr_PC_Plus4_IN = '0;
    Instr_Valid_IN = 1'b0; Request_Instr1 = 1'b0; Stall_IN = 1'b0; Flush_IN = 1'b0;

    // Reset
    step(0, 0, 0, 0, 0, 1, 0, -1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check_empty("reset");
    chk("reset_full", 32'(Full_OUT), 32'd0);

    // Fill to full; the 9th offer is dropped
    for (int i = 0; i < 8; i++)
      step(1, 32'h0040_0000 + 32'(4*i), 0, 0, 0, 0, 1, i);
    step(1, 32'h0040_0020, 0, 0, 0, 0, 0, 8);
    chk("full_flag", 32'(Full_OUT), 32'd1);

    // Drain in order, then check that the queue is empty
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, 8 - i);
      if (i == 0) chk("full_while_deq", 32'(Full_OUT), 32'd1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_empty("drained");
    chk("drained_full", 32'(Full_OUT), 32'd0);

    // Continuous enqueue+dequeue with 3 entries resident: pointers wrap
    for (int i = 0; i < 3; i++)
      step(1, 32'h0040_0040 + 32'(4*i), 0, 0, 0, 0, 1, i);
    for (int i = 0; i < 20; i++)
      step(1, 32'h0040_0040 + 32'(4*(3+i)), 1, 0, 0, 0, 1, 3);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, 0, 0, 0, 3 - i);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Stall holds the head but still admits offers
    for (int i = 0; i < 5; i++)
      step(1, 32'h0040_0500 + 32'(4*i), 0, 0, 0, 0, 1, i);
    step(1, 32'h0040_0514, 1, 1, 0, 0, 1, 5);
    chk("stall_head0", Instr_PC_OUT, 32'h0040_0500);
    step(0, 0, 1, 1, 0, 0, 0, 6);
    chk("stall_head1", Instr_PC_OUT, 32'h0040_0500);
    step(1, 32'h0040_0518, 1, 1, 0, 0, 1, 6);
    chk("stall_head2", Instr_PC_OUT, 32'h0040_0500);
    step(0, 0, 0, 0, 0, 0, 0, 7);
    for (int i = 0; i < 7; i++)
      step(0, 0, 1, 0, 0, 0, 0, 7 - i);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Flush with 4 resident and a same-cycle offer
    for (int i = 0; i < 4; i++)
      step(1, 32'h0040_0600 + 32'(4*i), 0, 0, 0, 0, 1, i);
    step(1, 32'h0040_0100, 0, 0, 1, 0, 0, 4);
    step(1, 32'h0040_0200, 0, 0, 0, 0, 1, 0);
`ifdef IQ_BYPASS_EN
    chk("post_flush_valid", 32'(Instr1_Valid_OUT), 32'd1);
`else
    chk("post_flush_valid", 32'(Instr1_Valid_OUT), 32'd0);
`endif
    step(0, 0, 1, 0, 0, 0, 0, 1);
    chk("post_flush_head", Instr_PC_OUT, 32'h0040_0200);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_empty("flush_done");

    // Offer into an empty queue while decode requests
    step(1, 32'h0040_0300, 1, 0, 0, 0, 1, 0);
`ifdef IQ_BYPASS_EN
    chk("byp_valid", 32'(Instr1_Valid_OUT), 32'd1);
    chk("byp_pc", Instr_PC_OUT, 32'h0040_0300);
    step(0, 0, 1, 0, 0, 0, 0, 0);
`else
    chk("nobyp_valid", 32'(Instr1_Valid_OUT), 32'd0);
    step(0, 0, 1, 0, 0, 0, 0, 1);
    chk("nobyp_pc", Instr_PC_OUT, 32'h0040_0300);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_empty("byp_done");

    // Reset mid-operation overrides a request and an offer
    for (int i = 0; i < 3; i++)
      step(1, 32'h0040_0700 + 32'(4*i), 0, 0, 0, 0, 1, i);
    step(1, 32'h0040_0800, 1, 0, 0, 1, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_empty("midreset");
    chk("midreset_full", 32'(Full_OUT), 32'd0);

    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries (power of two, 2..64).
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on posedge CLK.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Instr_IN  input  32  fetched instruction word.
REQ-005 SHALL have port Instr_PC_IN  input  32  PC of Instr_IN.
REQ-006 SHALL have port Instr_PC_Plus4_IN  input  32  PC+4 of Instr_IN.
REQ-007 SHALL have port Instr_Valid_IN  input  1  fetch offers an entry this cycle.
REQ-008 SHALL have port Full_OUT  output  1  queue cannot accept; fetch holds its PC.
REQ-009 SHALL have port Request_Instr1  input  1  decode is ready to consume the head entry.
REQ-010 SHALL have port Stall_IN  input  1  downstream freeze (memory stall or decode freeze); blocks dequeue.
REQ-011 SHALL have port Flush_IN  input  1  redirect taken (Request_Alt_PC); discard all entries.
REQ-012 SHALL have port Instr1_OUT  output  32  head instruction to decode.
REQ-013 SHALL have port Instr_PC_OUT  output  32  head PC.
REQ-014 SHALL have port Instr_PC_Plus4_OUT  output  32  head PC+4.
REQ-015 SHALL have port Instr1_Valid_OUT  output  1  head outputs are valid.
REQ-016 SHALL have port Count_OUT  output  log2(DEPTH)+1  current occupancy.

Function
REQ-017 Storage SHALL be a circular buffer with head/tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 Enqueue SHALL occur when Instr_Valid_IN=1, Full_OUT=0, Flush_IN=0; entry written at tail, tail+1.
REQ-019 Dequeue SHALL occur when Request_Instr1=1, Instr1_Valid_OUT=1, Stall_IN=0, Flush_IN=0; head+1.
REQ-020 Simultaneous enqueue and dequeue SHALL leave Count_OUT unchanged.
REQ-021 Full_OUT SHALL be 1 exactly when Count_OUT=DEPTH; an offer while full is ignored even if a dequeue occurs that cycle.
REQ-022 Outputs SHALL be show-ahead: Instr1_OUT/Instr_PC_OUT/Instr_PC_Plus4_OUT reflect the head entry combinationally from stored state.
REQ-023 When empty (and no bypass per REQ-031), Instr1_Valid_OUT SHALL be 0 and the three data outputs SHALL be 0 (decode sees a NOP).
REQ-024 Flush_IN=1 SHALL, at the next edge, set head=tail=0, Count_OUT=0; any same-cycle offer is dropped (wrong path).
REQ-025 Flush_IN SHALL take priority over Stall_IN, enqueue and dequeue.
REQ-026 Stall_IN=1 SHALL NOT block enqueue; the head entry stays stable for all stalled cycles.
REQ-027 Count_OUT SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-028 RESET=1 at a posedge SHALL set head=0, tail=0, Count_OUT=0, Full_OUT=0, Instr1_Valid_OUT=0, data outputs 0; storage contents need not clear.
REQ-029 RESET SHALL override all other inputs, including mid-operation with entries present; offers during reset are dropped.

Configuration
REQ-030 Macro IQ_BYPASS_EN SHALL select empty-queue fall-through.
REQ-031 With IQ_BYPASS_EN defined: when Count_OUT=0, Instr_Valid_IN=1, Flush_IN=0, outputs SHALL present Instr_IN/PC/PC+4 with Instr1_Valid_OUT=1 the same cycle; if dequeued that cycle the entry is not stored and Count_OUT stays 0.
REQ-032 Without IQ_BYPASS_EN: enqueue-to-visible latency SHALL be exactly 1 cycle; Instr1_Valid_OUT depends only on registered state.

Verification
REQ-033 Reset, then enqueue PCs 0x400000..0x40001C (8 entries) with Request_Instr1=0 -> Full_OUT=1, Count_OUT=8; 9th offer (0x400020) dropped.
REQ-034 From full, Request_Instr1=1 for 8 cycles -> outputs 0x400000..0x40001C in order, then Instr1_Valid_OUT=0, data 0.
REQ-035 Continuous enqueue+dequeue for 20 cycles -> pointers wrap, PCs emerge in order, Count_OUT constant.
REQ-036 Count_OUT=5, Stall_IN=1 with Request_Instr1=1 for 3 cycles plus 2 offers -> head PC unchanged, Count_OUT=7.
REQ-037 Count_OUT=4, Flush_IN=1 with offer PC 0x400100 same cycle -> next cycle Count_OUT=0, valid=0; offer 0x400200 next -> it is the head.
REQ-038 Empty, offer PC 0x400300 with Request_Instr1=1 -> IQ_BYPASS_EN: Instr_PC_OUT=0x400300 same cycle, Count_OUT stays 0; without: valid next cycle, then dequeued.
